free_list: RTL and testbench
============================

# free_list

Circular FIFO of free physical register tags, the supplier side of the rename interface. At dispatch it hands the next free tag (`T_idx`) to the map table and the ROB. At retire it reclaims the `T_old` tag that the ROB returns. On a branch rollback it restores its head pointer from a per-ROB-entry snapshot, so the tags handed to squashed instructions become free again without being pushed back.

## Interface
Parameters:
- `NUM_PR`, 64: physical registers. Tag width `PR_W = $clog2(NUM_PR)` = 6.
- `NUM_FL`, 32: free-list depth, `NUM_PR - 32`. Must be a power of two.
- `NUM_ROB`, 32: ROB entries, one head snapshot per entry.

Ports (reset is `reset`, synchronous, active-high; clock is `clock`):
- `clock`  in  1  system clock
- `reset`  in  1  synchronous active-high reset
- `en`  in  1  global stall. When 0, all state holds, including snapshots.
- `dispatch_en`  in  1  pop one tag this cycle
- `ROB_tail_idx`  in  `$clog2(NUM_ROB)`  ROB slot of the dispatching instruction; selects the snapshot to write
- `retire_en`  in  1  push `T_old` this cycle
- `T_old`  in  `PR_W`  tag freed by the retiring instruction
- `rollback_en`  in  1  squash younger instructions
- `ROB_rollback_idx`  in  `$clog2(NUM_ROB)`  ROB slot of the mispredicted branch
- `T_idx`  out  `PR_W`  tag at head, combinational from registers
- `free_valid`  out  1  list non-empty; dispatch may pop
- `free_num`  out  `$clog2(NUM_FL)+1`  free-entry count (0..32)

## Operation
- State:
  - `entry[NUM_FL]` of `PR_W` bits.
  - `head` and `tail`, each `$clog2(NUM_FL)+1` bits. The MSB is the wrap bit.
  - `backup_head[NUM_ROB]`.
- Count: `free_num = tail - head`, modulo 2^(`$clog2(NUM_FL)+1`). The list is full when the indices are equal and the wrap bits differ; empty when `head == tail`.
- Pop: when `dispatch_en && free_valid && !rollback_en`:
  - `head` increments by 1.
  - `backup_head[ROB_tail_idx]` is written with the incremented head, i.e. the post-allocation head.
- Push: when `retire_en`, `entry[tail[idx]] <= T_old` and `tail` increments by 1.
- Rollback: `head <= backup_head[ROB_rollback_idx]`. The branch keeps its own tag. Tail and push are unaffected.
- Priority for head: rollback over pop. Dispatch in a rollback cycle is dropped and writes no snapshot.
- Pop when empty (`dispatch_en && !free_valid`): ignored. Dispatch control must stall on `free_valid = 0`.
- Push when full: illegal. Guard with an assertion; the push is ignored in RTL.
- No bypass: a tag pushed in cycle N is poppable from cycle N+1 at the earliest.
- Tag 31 (zero register) is never in the list. Dispatch does not assert `dispatch_en` for dest 31.

## Timing
- Reset values:
  - `entry[i] = 32 + i`
  - `head = 0`, `tail = 32` (index 0, wrap bit 1)
  - `backup_head[*] = 0`
  - Outputs: `T_idx = 32`, `free_valid = 1`, `free_num = 32`
- `T_idx`, `free_valid` and `free_num` are valid in the same cycle they are sampled. The popped tag is the one presented on `T_idx` during the `dispatch_en` cycle.
- All updates take effect at the next posedge with `en = 1`.
- Simultaneous pop and push: both occur; `free_num` is unchanged.
- Simultaneous rollback and push: `head` is restored and `tail` advances; `free_num` is recomputed from the new pointers.
- Reset mid-operation restores the full list regardless of `en` or pending traffic.
- Wrap-around: pointer indices roll over from 31 to 0 and the wrap bit toggles.

## Structure
- Shared package (with the map table's `T_t`):
  - `NUM_PR`, `NUM_FL`, `NUM_ROB`
  - `FL_PTR_t`
  - `FREE_LIST_PACKET_IN` / `FREE_LIST_PACKET_OUT` structs
  - `FREE_LIST_RESET`
- Single flat module, no sub-modules. The snapshot array is a plain register file inside the block.

## Test plan
- Reset -> `T_idx = 32`, `free_num = 32`, `free_valid = 1`.
- 3 consecutive pops -> tags 32, 33, 34 are consumed; then `T_idx = 35`, `free_num = 29`.
- 32 pops -> `free_valid = 0`, `free_num = 0`. A 33rd `dispatch_en` leaves the pointers unchanged. One push of `T_old = 5` -> next cycle `T_idx = 5`, `free_num = 1`.
- Pop at `ROB_tail_idx = 4` (tag 32), then 2 more pops, then rollback to idx 4 -> `T_idx = 33`, `free_num = 31`.
- Rollback, pop and push of `T_old = 7` in the same cycle -> the pop is dropped, head is restored, tail advances, and `free_num` equals the restored count + 1.
- Pop and push of `T_old = 9` together with the list full -> `free_num` stays 32; 9 appears on `T_idx` after 31 further pops. Hold `en = 0` for 3 cycles with requests active -> no state change.

Source files
------------

// File: rtl/free_list_pkg.sv
// Shared rename-interface types: physical tag type, free-list pointer type,
// the free list's request/response packets and its reset response.
package free_list_pkg;

    localparam int NUM_PR   = 64;
    localparam int NUM_FL   = NUM_PR - 32;
    localparam int NUM_ROB  = 32;
    localparam int PR_W     = $clog2(NUM_PR);
    localparam int FL_IDX_W = $clog2(NUM_FL);
    localparam int FL_PTR_W = FL_IDX_W + 1;
    localparam int ROB_W    = $clog2(NUM_ROB);

    typedef logic [PR_W-1:0]     T_t;
    typedef logic [FL_PTR_W-1:0] FL_PTR_t;
    typedef logic [ROB_W-1:0]    ROB_IDX_t;

    typedef struct packed {
        logic     dispatch_en;
        ROB_IDX_t ROB_tail_idx;
        logic     retire_en;
        T_t       T_old;
        logic     rollback_en;
        ROB_IDX_t ROB_rollback_idx;
    } FREE_LIST_PACKET_IN;

    typedef struct packed {
        T_t      T_idx;
        logic    free_valid;
        FL_PTR_t free_num;
    } FREE_LIST_PACKET_OUT;

    localparam FREE_LIST_PACKET_OUT FREE_LIST_RESET = '{
        T_idx:      T_t'(NUM_PR - NUM_FL),
        free_valid: 1'b1,
        free_num:   FL_PTR_t'(NUM_FL)
    };

    // Slot i of a freshly reset list holds the i-th tag above the architectural registers.
    function automatic T_t reset_tag(input int i);
        return T_t'(NUM_PR - NUM_FL + i);
    endfunction

endpackage

// File: rtl/free_list_chk.sv
// Protocol checker for the free list: retire must never push into a full list
// unless a pop retires the head slot in the same cycle.
module free_list_chk
    import free_list_pkg::*;
(
    input logic                clock,
    input logic                reset,
    input logic                en,
    input logic                dispatch_en,
    input logic                retire_en,
    input logic                rollback_en,
    input logic [FL_PTR_W-1:0] free_num
);

    logic full_s;

    assign full_s = (free_num == FL_PTR_t'(NUM_FL));

    // A full list accepts a push only alongside a pop that actually fires.
    push_when_full_a: assert property (@(posedge clock) disable iff (reset)
        (en && retire_en && full_s) |-> (dispatch_en && !rollback_en))
        else $error("free_list push while full");

endmodule

// File: rtl/free_list.sv
// Circular FIFO of free physical tags with a head snapshot per ROB entry,
// so a branch rollback frees every squashed tag in one cycle.
module free_list
    import free_list_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                en,
    input  logic                dispatch_en,
    input  logic [ROB_W-1:0]    ROB_tail_idx,
    input  logic                retire_en,
    input  logic [PR_W-1:0]     T_old,
    input  logic                rollback_en,
    input  logic [ROB_W-1:0]    ROB_rollback_idx,
    output logic [PR_W-1:0]     T_idx,
    output logic                free_valid,
    output logic [FL_PTR_W-1:0] free_num
);

    FREE_LIST_PACKET_IN  in_pkt_s;
    FREE_LIST_PACKET_OUT out_pkt_s;

    T_t      entry_r       [NUM_FL];
    FL_PTR_t backup_head_r [NUM_ROB];
    FL_PTR_t head_r;
    FL_PTR_t tail_r;

    FL_PTR_t free_num_s;
    logic    free_valid_s;
    logic    full_s;
    logic    pop_s;
    logic    push_s;
    FL_PTR_t head_inc_s;
    FL_PTR_t head_nxt_s;
    FL_PTR_t tail_nxt_s;

    assign in_pkt_s = '{
        dispatch_en:      dispatch_en,
        ROB_tail_idx:     ROB_tail_idx,
        retire_en:        retire_en,
        T_old:            T_old,
        rollback_en:      rollback_en,
        ROB_rollback_idx: ROB_rollback_idx
    };

    // Wrap-bit pointers make tail - head the exact count, 0 through NUM_FL.
    always_comb begin
        free_num_s   = tail_r - head_r;
        free_valid_s = (free_num_s != FL_PTR_t'(0));
        full_s       = (free_num_s == FL_PTR_t'(NUM_FL));
    end

    assign out_pkt_s = '{
        T_idx:      entry_r[head_r[FL_IDX_W-1:0]],
        free_valid: free_valid_s,
        free_num:   free_num_s
    };

    assign T_idx      = out_pkt_s.T_idx;
    assign free_valid = out_pkt_s.free_valid;
    assign free_num   = out_pkt_s.free_num;

    // Next pointers: rollback beats pop; a push into a full list only lands when the head slot is vacated.
    always_comb begin
        pop_s      = in_pkt_s.dispatch_en && free_valid_s && !in_pkt_s.rollback_en;
        push_s     = in_pkt_s.retire_en && (!full_s || pop_s);
        head_inc_s = head_r + FL_PTR_t'(1);
        if (in_pkt_s.rollback_en) begin
            head_nxt_s = backup_head_r[in_pkt_s.ROB_rollback_idx];
        end else if (pop_s) begin
            head_nxt_s = head_inc_s;
        end else begin
            head_nxt_s = head_r;
        end
        if (push_s) begin
            tail_nxt_s = tail_r + FL_PTR_t'(1);
        end else begin
            tail_nxt_s = tail_r;
        end
    end

    // Pointer, tag storage and snapshot state; the snapshot records the post-allocation head.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_r <= FL_PTR_t'(0);
            tail_r <= FL_PTR_t'(NUM_FL);
            for (int i = 0; i < NUM_FL; i++) begin
                entry_r[i] <= reset_tag(i);
            end
            for (int r = 0; r < NUM_ROB; r++) begin
                backup_head_r[r] <= FL_PTR_t'(0);
            end
        end else if (en) begin
            head_r <= head_nxt_s;
            tail_r <= tail_nxt_s;
            if (push_s) begin
                entry_r[tail_r[FL_IDX_W-1:0]] <= in_pkt_s.T_old;
            end
            if (pop_s) begin
                backup_head_r[in_pkt_s.ROB_tail_idx] <= head_inc_s;
            end
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: the model is an unbounded log of every tag ever supplied,
// with the head kept as an absolute position into that log.
module tb_free_list;
    import free_list_pkg::*;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                en = 1'b0;
    logic                dispatch_en = 1'b0;
    logic [ROB_W-1:0]    ROB_tail_idx = '0;
    logic                retire_en = 1'b0;
    logic [PR_W-1:0]     T_old = '0;
    logic                rollback_en = 1'b0;
    logic [ROB_W-1:0]    ROB_rollback_idx = '0;
    logic [PR_W-1:0]     T_idx;
    logic                free_valid;
    logic [FL_PTR_W-1:0] free_num;

    int checks = 0;
    int errors = 0;

    // Model: log_q[k] is the k-th tag ever made available; free tags are log_q[m_head .. size-1].
    int log_q[$];
    int m_head;
    int snap[NUM_ROB];
    bit model_live = 1'b0;

    free_list dut (
        .clock(clock), .reset(reset), .en(en),
        .dispatch_en(dispatch_en), .ROB_tail_idx(ROB_tail_idx),
        .retire_en(retire_en), .T_old(T_old),
        .rollback_en(rollback_en), .ROB_rollback_idx(ROB_rollback_idx),
        .T_idx(T_idx), .free_valid(free_valid), .free_num(free_num)
    );

    free_list_chk u_chk (
        .clock(clock), .reset(reset), .en(en),
        .dispatch_en(dispatch_en), .retire_en(retire_en),
        .rollback_en(rollback_en), .free_num(free_num)
    );

    always #5 clock = ~clock;

    function automatic int m_num();
        return log_q.size() - m_head;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        log_q.delete();
        for (int i = 0; i < NUM_FL; i++) log_q.push_back(NUM_PR - NUM_FL + i);
        m_head = 0;
        for (int r = 0; r < NUM_ROB; r++) snap[r] = 0;
        model_live = 1'b1;
    endtask

    task automatic model_apply(input int e, input int d, input int ti, input int r,
                               input int to, input int rb, input int ri, input int rs);
        bit pop;
        bit push;
        if (rs != 0) begin
            model_reset();
        end else if (e != 0) begin
            pop  = (d != 0) && (m_num() > 0) && (rb == 0);
            push = (r != 0) && ((m_num() < NUM_FL) || pop);
            if (rb != 0) begin
                m_head = snap[ri];
            end else if (pop) begin
                m_head++;
                snap[ti] = m_head;
            end
            if (push) log_q.push_back(to);
        end
    endtask

    // Drive one cycle of requests, then fold their effect into the model after the edge.
    task automatic step(input int e, input int d, input int ti, input int r,
                        input int to, input int rb, input int ri, input int rs);
        en               = (e != 0);
        dispatch_en      = (d != 0);
        ROB_tail_idx     = ROB_W'(ti);
        retire_en        = (r != 0);
        T_old            = PR_W'(to);
        rollback_en      = (rb != 0);
        ROB_rollback_idx = ROB_W'(ri);
        reset            = (rs != 0);
        @(posedge clock);
        #1;
        model_apply(e, d, ti, r, to, rb, ri, rs);
    endtask

    task automatic pop(input int ti);
        step(1, 1, ti, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Hand-derived expectations applied to both the DUT and the model.
    task automatic pin(input string name, input int tag, input int num);
        if (num > 0) chk({name, " T_idx"}, T_idx, tag);
        chk({name, " free_num"}, free_num, num);
        chk({name, " free_valid"}, free_valid, (num > 0) ? 1 : 0);
        chk({name, " model free_num"}, m_num(), num);
        if (num > 0) chk({name, " model tag"}, log_q[m_head], tag);
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (model_live && !reset) begin
            chk("free_num", free_num, m_num());
            chk("free_valid", free_valid, (m_num() > 0) ? 1 : 0);
            if (m_num() > 0) chk("T_idx", T_idx, log_q[m_head]);
        end
    end

    initial begin
        int e, d, ti, r, to, rb, ri, pd, cnt;
        bit pop_ok;

        do_reset();
        pin("reset", 32, 32);

        for (int k = 0; k < 3; k++) begin
            chk("pop tag", T_idx, 32 + k);
            pop(k);
        end
        pin("three pops", 35, 29);

        do_reset();
        for (int k = 0; k < 32; k++) pop(k);
        pin("drained", 0, 0);
        pop(0);
        pin("pop when empty", 0, 0);
        step(1, 0, 0, 1, 5, 0, 0, 0);
        pin("refill", 5, 1);

        do_reset();
        pop(4);
        pop(5);
        pop(6);
        step(1, 0, 0, 0, 0, 1, 4, 0);
        pin("rollback", 33, 31);
        pop(10);
        pop(11);
        step(1, 1, 12, 1, 7, 1, 10, 0);
        pin("rollback with push", 34, 31);

        do_reset();
        step(1, 1, 0, 1, 9, 0, 0, 0);
        pin("full pop and push", 33, 32);
        for (int k = 0; k < 31; k++) pop(k);
        pin("wrapped tag", 9, 1);
        for (int k = 0; k < 3; k++) step(0, 1, 3, 1, 20, 1, 5, 0);
        pin("stalled", 9, 1);
        step(0, 1, 0, 1, 3, 0, 0, 1);
        pin("reset while stalled", 32, 32);

        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) do_reset();
            pd = ((c / 150) % 2 == 1) ? 80 : 30;
            e  = ($urandom_range(0, 99) < 92) ? 1 : 0;
            d  = ($urandom_range(0, 99) < pd) ? 1 : 0;
            ti = $urandom_range(0, NUM_ROB - 1);
            ri = $urandom_range(0, NUM_ROB - 1);
            rb = 0;
            if ($urandom_range(0, 99) < 8 && snap[ri] <= m_head &&
                log_q.size() - snap[ri] <= NUM_FL) rb = 1;
            r  = ($urandom_range(0, 99) < (100 - pd)) ? 1 : 0;
            to = $urandom_range(0, NUM_PR - 2);
            if (to >= 31) to++;
            cnt    = m_num();
            pop_ok = (d != 0) && (cnt > 0) && (rb == 0);
            if (r != 0 && e != 0) begin
                if (rb != 0) begin
                    if (log_q.size() + 1 - snap[ri] > NUM_FL) r = 0;
                end else if (cnt >= NUM_FL && !pop_ok) begin
                    r = 0;
                end
            end
            step(e, d, ti, r, to, rb, ri, 0);
        end

        @(negedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
